neuron_dot_seq: RTL and testbench
=================================

Name: neuron_dot_seq

Overview:
- Parametrised successor to the single-input neuron: a streamed dot product of up to N_INPUTS (x,w) pairs plus bias, followed by activation and signed saturation.
- One multiply-accumulate per accepted beat.
- valid/ready handshake on both input and output.
- Building block for multi-input layers in the neuron datapath.

Parameters:
- DATA_W, 8: signed width of x, w and bias.
- N_INPUTS, 4: maximum beats per vector (>=1).
- OUT_W, 18: signed width of y.
- ACC_W, 2*DATA_W+$clog2(N_INPUTS)+1: accumulator width. Derived; not overridden.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  beat valid.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- x  in  DATA_W  signed activation input.
- w  in  DATA_W  signed weight.
- bias  in  DATA_W  signed bias; sampled on the first beat of a vector only.
- in_last  in  1  marks the final beat of a vector.
- y  out  OUT_W  signed result.
- y_valid  out  1  result valid.
- y_ready  in  1  result consumed when y_valid && y_ready.
- sat  out  1  result was clamped; valid with y_valid.
- err_len  out  1  sticky: a vector reached N_INPUTS beats without in_last.

Behaviour:
- Reset (rst=1 at a clk edge):
  - State IDLE.
  - y=0, y_valid=0, sat=0, err_len=0.
  - Accumulator, beat counter and bias register cleared.
  - A partial vector is discarded.
- States and transitions:
  - IDLE, in_ready=1. On an accepted beat: acc = sext(x*w), bias_r = bias, cnt = 1.
    - in_last=1 or N_INPUTS=1 -> ADD.
    - Otherwise -> ACCUM.
  - ACCUM, in_ready=1. On an accepted beat: acc += sext(x*w), cnt++.
    - Goes to ADD when in_last=1, or when cnt+1 == N_INPUTS.
    - Reaching N_INPUTS without in_last sets err_len; that beat is treated as last.
  - ADD, in_ready=0. sum_r = acc + sext(bias_r) -> ACT.
  - ACT, in_ready=0.
    - y = act(sat(sum_r)).
    - sat = 1 if sum_r is outside [-2^(OUT_W-1), 2^(OUT_W-1)-1].
    - y_valid=1 -> OUT.
  - OUT, in_ready=0. y, sat and y_valid held stable until y_ready=1. The handshake edge clears y_valid -> IDLE.
- Latency: y_valid rises 2 clk edges after the edge accepting the last beat; no pipelining, one vector in flight.
- Arithmetic:
  - Products are full 2*DATA_W signed; all sign-extension is explicit.
  - ACC_W cannot overflow for any N_INPUTS-beat vector plus bias.
- Saturation is applied before activation. Clamp to the max positive or min negative OUT_W value.
- act: ReLU. A negative saturated value gives y=0. sat still reflects clamping, even when y=0.
- in_valid is ignored when in_ready=0. x, w and in_last need not be held.
- bias on non-first beats is ignored.
- Reset has priority over all events, including an accepted beat or output handshake in the same cycle.
- err_len clears only on rst.

Optional Feature:
- LEAKY_RELU_EN defined: negative saturated values output as value >>> 3 (arithmetic shift, rounds toward -inf), e.g. -21 -> -3. Positive values unchanged.
- LEAKY_RELU_EN undefined: plain ReLU, negatives -> 0.
- Port list identical in both builds.

Test Plan:
- Single beat x=3 w=2 bias=1 in_last=1 -> y=7, sat=0, y_valid exactly 2 edges after acceptance, in_ready=0 until handshake.
- Four beats x=10 w=10, bias=-5 on beat 1 (bias=99 on beats 2-4), in_last on beat 4; in_valid gapped 1 cycle between beats -> y=395.
- x=-5 w=5 bias=4 single beat -> y=0 (ReLU); with LEAKY_RELU_EN -> y=-3.
- OUT_W=12 instance, four beats x=-128 w=-128, bias=127 -> sum 65663, y=2047, sat=1.
- y_ready held low 5 cycles after y_valid -> y/sat/y_valid stable, in_ready=0; y_ready=1 -> IDLE next edge, next vector (3,2,1) -> y=7.
- Four beats, no in_last (N_INPUTS=4) -> vector ends after beat 4, err_len=1 and stays set. Then rst=1 after 2 beats of a new vector -> all outputs 0, err_len=0; next vector (3,2,1) -> y=7.

Source files
------------

// File: rtl/neuron_dot_if.sv
// Handshake bundle for neuron_dot_seq: streamed (x,w,bias,last) beats in, saturated y out.
// A transfer happens on a rising edge where valid && ready; the producer holds its data until then.
interface neuron_dot_if #(
    parameter int DATA_W = 8,
    parameter int OUT_W  = 18
);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] x;
    logic signed [DATA_W-1:0] w;
    logic signed [DATA_W-1:0] bias;
    logic                     in_last;
    logic signed [OUT_W-1:0]  y;
    logic                     y_valid;
    logic                     y_ready;
    logic                     sat;
    logic                     err_len;

    modport master (
        output in_valid, x, w, bias, in_last, y_ready,
        input  in_ready, y, y_valid, sat, err_len
    );

    modport slave (
        input  in_valid, x, w, bias, in_last, y_ready,
        output in_ready, y, y_valid, sat, err_len
    );
endinterface

// File: rtl/neuron_dot_seq.sv
// Streamed dot product of up to N_INPUTS (x,w) beats plus bias, saturated to OUT_W then ReLU.
// Define LEAKY_RELU_EN to output negative saturated values as value >>> 3 instead of 0.
module neuron_dot_seq #(
    parameter int DATA_W   = 8,
    parameter int N_INPUTS = 4,
    parameter int OUT_W    = 18
) (
    input  logic        clk,
    input  logic        rst,
    neuron_dot_if.slave s_if,
    output logic [2:0]  o_dbg_state
);
    localparam int ACC_W  = 2*DATA_W + $clog2(N_INPUTS) + 1;
    localparam int PROD_W = 2*DATA_W;
    localparam int CNT_W  = $clog2(N_INPUTS + 1);
    localparam int EXT_W  = (ACC_W > OUT_W) ? ACC_W : OUT_W;
    localparam logic signed [EXT_W-1:0] SAT_MAX = EXT_W'((64'sd1 <<< (OUT_W-1)) - 64'sd1);
    localparam logic signed [EXT_W-1:0] SAT_MIN = ~SAT_MAX;
    localparam logic signed [OUT_W-1:0] Y_MAX   = SAT_MAX[OUT_W-1:0];
    localparam logic signed [OUT_W-1:0] Y_MIN   = SAT_MIN[OUT_W-1:0];

    typedef enum logic [2:0] {S_IDLE, S_ACCUM, S_ADD, S_ACT, S_OUT} state_t;

    state_t                   r_state, w_next;
    logic signed [ACC_W-1:0]  r_acc, r_sum;
    logic signed [DATA_W-1:0] r_bias;
    logic [CNT_W-1:0]         r_cnt;
    logic signed [OUT_W-1:0]  r_y;
    logic                     r_y_valid, r_sat, r_err_len;

    logic signed [PROD_W-1:0] w_prod;
    logic signed [ACC_W-1:0]  w_prod_ext, w_bias_ext;
    logic [CNT_W-1:0]         w_beat_no;
    logic                     w_len_hit, w_vec_end;
    logic signed [EXT_W-1:0]  w_sum_ext;
    logic                     w_over, w_under;
    logic signed [OUT_W-1:0]  w_clamped, w_act;

    assign w_prod     = s_if.x * s_if.w;
    assign w_prod_ext = {{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};
    assign w_bias_ext = {{(ACC_W-DATA_W){r_bias[DATA_W-1]}}, r_bias};

    // Beat number of the beat currently offered; hitting N_INPUTS closes the vector.
    assign w_beat_no = (r_state == S_IDLE) ? CNT_W'(1) : r_cnt + CNT_W'(1);
    assign w_len_hit = (w_beat_no == CNT_W'(N_INPUTS));
    assign w_vec_end = s_if.in_last || w_len_hit;

    assign w_sum_ext = EXT_W'(r_sum);
    assign w_over    = (w_sum_ext > SAT_MAX);
    assign w_under   = (w_sum_ext < SAT_MIN);
    assign w_clamped = w_over ? Y_MAX : (w_under ? Y_MIN : w_sum_ext[OUT_W-1:0]);

`ifdef LEAKY_RELU_EN
    assign w_act = w_clamped[OUT_W-1] ? (w_clamped >>> 3) : w_clamped;
`else
    assign w_act = w_clamped[OUT_W-1] ? '0 : w_clamped;
`endif

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next        = r_state;
        s_if.in_ready = 1'b0;
        case (r_state)
            S_IDLE: begin
                s_if.in_ready = 1'b1;
                if (s_if.in_valid) w_next = w_vec_end ? S_ADD : S_ACCUM;
            end
            S_ACCUM: begin
                s_if.in_ready = 1'b1;
                if (s_if.in_valid && w_vec_end) w_next = S_ADD;
            end
            S_ADD:   w_next = S_ACT;
            S_ACT:   w_next = S_OUT;
            S_OUT:   if (s_if.y_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // in_ready is high exactly in IDLE/ACCUM, so in_valid there means an accepted beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc     <= '0;
            r_sum     <= '0;
            r_bias    <= '0;
            r_cnt     <= '0;
            r_y       <= '0;
            r_y_valid <= 1'b0;
            r_sat     <= 1'b0;
            r_err_len <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (s_if.in_valid) begin
                    r_acc  <= w_prod_ext;
                    r_bias <= s_if.bias;
                    r_cnt  <= w_beat_no;
                    if (w_len_hit && !s_if.in_last) r_err_len <= 1'b1;
                end
                S_ACCUM: if (s_if.in_valid) begin
                    r_acc <= r_acc + w_prod_ext;
                    r_cnt <= w_beat_no;
                    if (w_len_hit && !s_if.in_last) r_err_len <= 1'b1;
                end
                S_ADD: r_sum <= r_acc + w_bias_ext;
                S_ACT: begin
                    r_y       <= w_act;
                    r_sat     <= w_over || w_under;
                    r_y_valid <= 1'b1;
                end
                S_OUT: if (s_if.y_ready) r_y_valid <= 1'b0;
                default: ;
            endcase
        end
    end

    assign s_if.y       = r_y;
    assign s_if.y_valid = r_y_valid;
    assign s_if.sat     = r_sat;
    assign s_if.err_len = r_err_len;
    assign o_dbg_state  = r_state;
endmodule

// File: tb/tb_neuron_dot_seq.sv
// Directed bench for neuron_dot_seq: an OUT_W=18 instance (a) and an OUT_W=12 instance (b).
module tb_neuron_dot_seq;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic tb_sel, tb_valid, tb_last, tb_y_ready;
    logic signed [7:0] tb_x, tb_w, tb_bias;

    neuron_dot_if #(.DATA_W(8), .OUT_W(18)) if_a ();
    neuron_dot_if #(.DATA_W(8), .OUT_W(12)) if_b ();
    logic [2:0] dbg_a, dbg_b;

    assign if_a.in_valid = tb_valid && !tb_sel;
    assign if_b.in_valid = tb_valid && tb_sel;
    assign if_a.x = tb_x;        assign if_b.x = tb_x;
    assign if_a.w = tb_w;        assign if_b.w = tb_w;
    assign if_a.bias = tb_bias;  assign if_b.bias = tb_bias;
    assign if_a.in_last = tb_last;
    assign if_b.in_last = tb_last;
    assign if_a.y_ready = tb_y_ready && !tb_sel;
    assign if_b.y_ready = tb_y_ready && tb_sel;

    neuron_dot_seq #(.DATA_W(8), .N_INPUTS(4), .OUT_W(18)) u_dut_a (
        .clk(clk), .rst(rst), .s_if(if_a), .o_dbg_state(dbg_a));
    neuron_dot_seq #(.DATA_W(8), .N_INPUTS(4), .OUT_W(12)) u_dut_b (
        .clk(clk), .rst(rst), .s_if(if_b), .o_dbg_state(dbg_b));

    logic              w_ready, w_y_valid, w_sat;
    logic signed [17:0] w_y;
    assign w_ready   = tb_sel ? if_b.in_ready : if_a.in_ready;
    assign w_y_valid = tb_sel ? if_b.y_valid  : if_a.y_valid;
    assign w_sat     = tb_sel ? if_b.sat      : if_a.sat;
    assign w_y       = tb_sel ? {{6{if_b.y[11]}}, if_b.y} : if_a.y;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        string            name;
        logic             sel;
        int               n;
        int               gap;
        logic [0:3][7:0]  x;
        logic [0:3][7:0]  w;
        logic signed [7:0] bias;
        int               exp_y;
        logic             exp_sat;
    } vec_t;

    function automatic int act(input int relu, input int leaky);
`ifdef LEAKY_RELU_EN
        return leaky;
`else
        return relu;
`endif
    endfunction

    function automatic vec_t mk(input string name, input logic sel, input int n, input int gap,
                                input int x0, input int w0, input int x1, input int w1,
                                input int x2, input int w2, input int x3, input int w3,
                                input int b, input int ey, input logic es);
        vec_t v;
        v.name = name; v.sel = sel; v.n = n; v.gap = gap;
        v.x = {8'(x0), 8'(x1), 8'(x2), 8'(x3)};
        v.w = {8'(w0), 8'(w1), 8'(w2), 8'(w3)};
        v.bias = 8'(b); v.exp_y = ey; v.exp_sat = es;
        return v;
    endfunction

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    task automatic send_beat(input logic sel, input logic signed [7:0] x, input logic signed [7:0] w,
                             input logic signed [7:0] b, input logic last);
        bit done = 0;
        tb_sel = sel; tb_x = x; tb_w = w; tb_bias = b; tb_last = last; tb_valid = 1'b1;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            if (w_ready) done = 1;
            @(posedge clk); #1;
        end
        tb_valid = 1'b0;
        if (!done) check("beat_accept_timeout", 0, 1);
    endtask

    task automatic get_result(output int y, output logic s);
        bit done = 0;
        y = 0; s = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            if (w_y_valid) begin
                done = 1; y = int'(w_y); s = w_sat;
            end
            @(posedge clk); #1;
        end
        if (!done) check("y_valid_timeout", 0, 1);
    endtask

    task automatic run_vec(input vec_t v);
        int y; logic s;
        for (int i = 0; i < v.n; i++) begin
            send_beat(v.sel, $signed(v.x[i]), $signed(v.w[i]), (i == 0) ? v.bias : 8'sd99,
                      i == v.n - 1);
            if (i != v.n - 1) repeat (v.gap) begin @(posedge clk); #1; end
        end
        get_result(y, s);
        check({v.name, "_y"}, y, v.exp_y);
        check({v.name, "_sat"}, int'(s), int'(v.exp_sat));
    endtask

    vec_t vecs[12];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int y; logic s;
        rst = 1'b1; tb_sel = 1'b0; tb_valid = 1'b0; tb_last = 1'b0; tb_y_ready = 1'b1;
        tb_x = '0; tb_w = '0; tb_bias = '0;

        vecs[0]  = mk("single",   0, 1, 0,    3,   2,    0,   0,   0,   0,   0,   0,    1, 7, 0);
        vecs[1]  = mk("gap4",     0, 4, 1,   10,  10,   10,  10,  10,  10,  10,  10,   -5, 395, 0);
        vecs[2]  = mk("relu_neg", 0, 1, 0,   -5,   5,    0,   0,   0,   0,   0,   0,    4, act(0, -3), 0);
        vecs[3]  = mk("two_max",  0, 2, 0,  127, 127, -128,-128,   0,   0,   0,   0,    0, 32513, 0);
        vecs[4]  = mk("neg4",     0, 4, 0, -128, 127, -128, 127,-128, 127,-128, 127, -128, act(0, -8144), 0);
        vecs[5]  = mk("mixed3",   0, 3, 2,    1,   2,   -3,   4,   5,   6,   0,   0,    7, 27, 0);
        vecs[6]  = mk("b_satpos", 1, 4, 0, -128,-128, -128,-128,-128,-128,-128,-128,  127, 2047, 1);
        vecs[7]  = mk("b_satneg", 1, 4, 0, -128, 127, -128, 127,-128, 127,-128, 127, -128, act(0, -256), 1);
        vecs[8]  = mk("b_at_max", 1, 1, 0,   23,  89,    0,   0,   0,   0,   0,   0,    0, 2047, 0);
        vecs[9]  = mk("b_max_p1", 1, 1, 0,   23,  89,    0,   0,   0,   0,   0,   0,    1, 2047, 1);
        vecs[10] = mk("b_at_min", 1, 1, 0, -128,  16,    0,   0,   0,   0,   0,   0,    0, act(0, -256), 0);
        vecs[11] = mk("b_min_m1", 1, 1, 0, -128,  16,    0,   0,   0,   0,   0,   0,   -1, act(0, -256), 1);

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("rst_y", int'(if_a.y), 0);
        check("rst_y_valid", int'(if_a.y_valid), 0);
        check("rst_sat", int'(if_a.sat), 0);
        check("rst_err_len", int'(if_a.err_len), 0);
        check("rst_in_ready", int'(if_a.in_ready), 1);
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) run_vec(vecs[i]);

        // Latency, output hold under back-pressure, and ignored in_valid while busy.
        tb_sel = 1'b0; tb_y_ready = 1'b0;
        send_beat(0, 8'sd3, 8'sd2, 8'sd1, 1'b1);
        @(negedge clk);
        check("lat_e1_valid", int'(if_a.y_valid), 0);
        check("lat_e1_ready", int'(if_a.in_ready), 0);
        @(negedge clk);
        check("lat_e2_valid", int'(if_a.y_valid), 0);
        @(negedge clk);
        check("lat_valid", int'(if_a.y_valid), 1);
        check("lat_y", int'(if_a.y), 7);
        check("lat_sat", int'(if_a.sat), 0);
        tb_valid = 1'b1; tb_x = 8'sd50; tb_w = 8'sd50; tb_last = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("hold_valid", int'(if_a.y_valid), 1);
            check("hold_y", int'(if_a.y), 7);
            check("hold_ready", int'(if_a.in_ready), 0);
        end
        tb_valid = 1'b0; tb_y_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("hs_valid_clr", int'(if_a.y_valid), 0);
        check("hs_idle_ready", int'(if_a.in_ready), 1);
        @(posedge clk); #1;
        run_vec(vecs[0]);

        // Four beats without in_last: vector closes on beat 4 and err_len sticks.
        for (int i = 0; i < 4; i++) send_beat(0, 8'sd1, 8'sd1, 8'sd0, 1'b0);
        @(negedge clk);
        check("len_ready_drop", int'(if_a.in_ready), 0);
        get_result(y, s);
        check("len_y", y, 4);
        check("len_err", int'(if_a.err_len), 1);
        run_vec(vecs[0]);
        check("len_err_sticky", int'(if_a.err_len), 1);

        // Reset in the middle of a vector discards it and clears err_len.
        send_beat(0, 8'sd20, 8'sd20, 8'sd5, 1'b0);
        send_beat(0, 8'sd20, 8'sd20, 8'sd5, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("mid_rst_y", int'(if_a.y), 0);
        check("mid_rst_valid", int'(if_a.y_valid), 0);
        check("mid_rst_sat", int'(if_a.sat), 0);
        check("mid_rst_err", int'(if_a.err_len), 0);
        check("mid_rst_ready", int'(if_a.in_ready), 1);
        @(posedge clk); #1;
        run_vec(vecs[0]);
        check("post_rst_err", int'(if_a.err_len), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
